// File: rtl/serving_counters_if.sv
// Request/response handshake between player-interaction logic and the serving counters.
// The player side drives requests and receives one-cycle ack/nack responses.
interface serving_counters_if;
    logic       req_valid;
    logic       req_op;
    logic       req_space;
    logic [3:0] req_item;
    logic       resp_ack;
    logic       resp_nack;
    logic [3:0] resp_item;

    modport master (
        output req_valid, req_op, req_space, req_item,
        input  resp_ack, resp_nack, resp_item
    );

    modport slave (
        input  req_valid, req_op, req_space, req_item,
        output resp_ack, resp_nack, resp_item
    );
endinterface

// File: rtl/serving_counters.sv
// Two serving-window spaces: settle a placed dish, present it downstream,
// detect consumption via out_spaces, time out unclaimed dishes, allow take-back.

module serving_space #(
    parameter int SETTLE_CYCLES = 4,
    parameter int REJECT_CYCLES = 1000,
    parameter int ITEM_W        = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              place_req,
    input  logic              take_req,
    input  logic [ITEM_W-1:0] place_item,
    input  logic [ITEM_W-1:0] out_item,
    output logic [ITEM_W-1:0] check_item,
    output logic [ITEM_W-1:0] held_item,
    output logic [ITEM_W-1:0] take_item,
    output logic              ack,
    output logic              nack,
    output logic              served,
    output logic              rejected
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = $clog2(REJECT_CYCLES);
    localparam logic [SW-1:0] SETTLE_LOAD  = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PRESENT_LAST = PW'(REJECT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_EMPTY     = 2'd0,
        S_SETTLING  = 2'd1,
        S_PRESENTED = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ITEM_W-1:0] item_q, item_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [PW-1:0]     present_q, present_d;
    logic              served_q, served_d;
    logic              rejected_q, rejected_d;
    logic              consume, timeout, holding, take_go, drop;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_EMPTY;
            item_q     <= '0;
            settle_q   <= '0;
            present_q  <= '0;
            served_q   <= 1'b0;
            rejected_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            item_q     <= item_d;
            settle_q   <= settle_d;
            present_q  <= present_d;
            served_q   <= served_d;
            rejected_q <= rejected_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        item_d     = item_q;
        settle_d   = settle_q;
        present_d  = present_q;
        served_d   = 1'b0;
        rejected_d = 1'b0;
        ack        = 1'b0;
        nack       = 1'b0;
        take_item  = '0;
        take_go    = 1'b0;
        drop       = 1'b0;

        // out_item is ignored on the first presented cycle (downstream register lag)
        consume = (state_q == S_PRESENTED) && (present_q != '0) && (out_item == '0);
        timeout = (state_q == S_PRESENTED) && (present_q == PRESENT_LAST);
        holding = (state_q != S_EMPTY);

        if (place_req) begin
            if (!holding && place_item != '0) begin
                ack      = 1'b1;
                state_d  = S_SETTLING;
                item_d   = place_item;
                settle_d = SETTLE_LOAD;
            end else begin
                nack = 1'b1;
            end
        end

        // consumption beats take; take beats timeout
        if (take_req) begin
            if (holding && !consume) begin
                ack       = 1'b1;
                take_item = item_q;
                take_go   = 1'b1;
                drop      = 1'b1;
            end else begin
                nack = 1'b1;
            end
        end

        unique case (state_q)
            S_SETTLING: begin
                if (!take_go) begin
                    if (settle_q == '0) begin
                        state_d   = S_PRESENTED;
                        present_d = '0;
                    end else begin
                        settle_d = settle_q - 1'b1;
                    end
                end
            end
            S_PRESENTED: begin
                if (consume) begin
                    served_d = 1'b1;
                    drop     = 1'b1;
                end else if (take_go) begin
                    drop = 1'b1;
                end else if (timeout) begin
                    rejected_d = 1'b1;
                    drop       = 1'b1;
                end else if (present_q != PRESENT_LAST) begin
                    present_d = present_q + 1'b1;
                end
            end
            default: ;
        endcase

        if (drop) begin
            state_d   = S_EMPTY;
            item_d    = '0;
            settle_d  = '0;
            present_d = '0;
        end
    end

    assign check_item = (state_q == S_PRESENTED) ? item_q : '0;
    assign held_item  = item_q;
    assign served     = served_q;
    assign rejected   = rejected_q;
endmodule

module serving_counters #(
    parameter int SETTLE_CYCLES = 4,
    parameter int REJECT_CYCLES = 1000
) (
    input  logic                  clock,
    input  logic                  reset,
    serving_counters_if.slave     bus,
    input  logic [1:0][3:0]       out_spaces,
    output logic [1:0][3:0]       check_spaces,
    output logic [1:0][3:0]       space_item,
    output logic [1:0]            served,
    output logic [1:0]            rejected
);
    localparam int NUM_SPACES = 2;
    localparam int ITEM_W     = 4;

    logic [NUM_SPACES-1:0]             ack_d, nack_d;
    logic [NUM_SPACES-1:0][ITEM_W-1:0] take_item_d;
    logic [ITEM_W-1:0]                 resp_item_d;

    for (genvar gi = 0; gi < NUM_SPACES; gi++) begin : g_space
        logic hit;
        assign hit = bus.req_valid && (bus.req_space == 1'(gi));

        serving_space #(
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .REJECT_CYCLES (REJECT_CYCLES),
            .ITEM_W        (ITEM_W)
        ) u_space (
            .clock      (clock),
            .reset      (reset),
            .place_req  (hit && !bus.req_op),
            .take_req   (hit && bus.req_op),
            .place_item (bus.req_item),
            .out_item   (out_spaces[gi]),
            .check_item (check_spaces[gi]),
            .held_item  (space_item[gi]),
            .take_item  (take_item_d[gi]),
            .ack        (ack_d[gi]),
            .nack       (nack_d[gi]),
            .served     (served[gi]),
            .rejected   (rejected[gi])
        );
    end

    // only the targeted space returns a nonzero item, so OR-merge is safe
    always_comb begin
        resp_item_d = '0;
        for (int i = 0; i < NUM_SPACES; i++) resp_item_d = resp_item_d | take_item_d[i];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            bus.resp_ack  <= 1'b0;
            bus.resp_nack <= 1'b0;
            bus.resp_item <= '0;
        end else begin
            bus.resp_ack  <= |ack_d;
            bus.resp_nack <= |nack_d;
            bus.resp_item <= resp_item_d;
        end
    end
endmodule

// File: tb/tb_serving_counters.sv
// Directed bench for serving_counters: scoreboard queues of expected responses and pulses,
// compared every cycle, plus direct checks of space contents.
module tb_serving_counters;
    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [1:0][3:0] out_spaces;
    logic [1:0][3:0] check_spaces;
    logic [1:0][3:0] space_item;
    logic [1:0]      served;
    logic [1:0]      rejected;

    serving_counters_if bus ();

    serving_counters #(.SETTLE_CYCLES(4), .REJECT_CYCLES(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .out_spaces   (out_spaces),
        .check_spaces (check_spaces),
        .space_item   (space_item),
        .served       (served),
        .rejected     (rejected)
    );

    always #5 clock = ~clock;

    int edges = 0;
    always @(posedge clock) edges <= edges + 1;

    typedef struct { int cyc; logic ack; logic nack; logic [3:0] item; } resp_t;
    typedef struct { int cyc; logic [1:0] srv; logic [1:0] rej; } pulse_t;

    resp_t  rq[$];
    pulse_t pq[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // advance one edge, then compare response and pulse outputs against the scoreboard
    task automatic tick();
        resp_t  re;
        pulse_t pe;
        @(posedge clock);
        #1;
        re = '{cyc: 0, ack: 1'b0, nack: 1'b0, item: 4'h0};
        pe = '{cyc: 0, srv: 2'b00, rej: 2'b00};
        if (rq.size() > 0 && rq[0].cyc == edges) re = rq.pop_front();
        if (pq.size() > 0 && pq[0].cyc == edges) pe = pq.pop_front();
        chk("resp", {2'b00, bus.resp_ack, bus.resp_nack, bus.resp_item},
                    {2'b00, re.ack, re.nack, re.item});
        chk("pulse", {4'h0, served, rejected}, {4'h0, pe.srv, pe.rej});
    endtask

    task automatic exp_pulse(input int cyc, input logic [1:0] srv, input logic [1:0] rej);
        pulse_t p;
        p.cyc = cyc; p.srv = srv; p.rej = rej;
        pq.push_back(p);
    endtask

    task automatic do_req(input logic op, input logic sp, input logic [3:0] it,
                          input logic eack, input logic enack, input logic [3:0] eitem);
        resp_t r;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_space = sp;
        bus.req_item  = it;
        r.cyc = edges + 1; r.ack = eack; r.nack = enack; r.item = eitem;
        rq.push_back(r);
        tick();
        bus.req_valid = 1'b0;
        bus.req_item  = 4'h0;
    endtask

    initial begin
        out_spaces    = {4'hF, 4'hF};
        bus.req_valid = 1'b1;
        bus.req_op    = 1'b0;
        bus.req_space = 1'b0;
        bus.req_item  = 4'h5;

        // reset with a live request: everything must stay quiet
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rst_check", check_spaces, 8'h00);
            chk("rst_item", space_item, 8'h00);
        end
        reset = 1'b0;
        bus.req_valid = 1'b0;
        tick();

        // place 5 on space 0, presented 4 edges later
        do_req(1'b0, 1'b0, 4'h5, 1'b1, 1'b0, 4'h0);
        chk("place_item0", {4'h0, space_item[0]}, 8'h05);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("settle_check0", {4'h0, check_spaces[0]}, 8'h00);
        end
        tick();
        chk("present_check0", {4'h0, check_spaces[0]}, 8'h05);

        // consumption on the second presented cycle
        tick();
        out_spaces[0] = 4'h0;
        exp_pulse(edges + 1, 2'b01, 2'b00);
        tick();
        chk("served_check0", {4'h0, check_spaces[0]}, 8'h00);
        chk("served_item0", {4'h0, space_item[0]}, 8'h00);
        out_spaces[0] = 4'hF;
        do_req(1'b0, 1'b0, 4'h3, 1'b1, 1'b0, 4'h0);
        chk("replace_item0", {4'h0, space_item[0]}, 8'h03);
        do_req(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h3);
        chk("take_item0", {4'h0, space_item[0]}, 8'h00);

        // occupied / illegal requests
        do_req(1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 4'h0);
        do_req(1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 4'h0);
        do_req(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0);
        do_req(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'h0);
        chk("occupied_item1", {4'h0, space_item[1]}, 8'h09);
        tick();
        chk("present_check1", {4'h0, check_spaces[1]}, 8'h09);

        // zero on the first presented cycle is ignored
        out_spaces[1] = 4'h0;
        tick();
        chk("ignore_first", {4'h0, check_spaces[1]}, 8'h09);

        // consumption beats take on the same edge
        exp_pulse(edges + 1, 2'b10, 2'b00);
        do_req(1'b1, 1'b1, 4'h0, 1'b0, 1'b1, 4'h0);
        chk("consume_item1", {4'h0, space_item[1]}, 8'h00);
        out_spaces[1] = 4'hF;

        // timeout after 16 presented cycles
        out_spaces[0] = 4'h7;
        do_req(1'b0, 1'b0, 4'h7, 1'b1, 1'b0, 4'h0);
        for (int k = 0; k < 4; k++) tick();
        chk("to_present", {4'h0, check_spaces[0]}, 8'h07);
        exp_pulse(edges + 16, 2'b00, 2'b01);
        for (int k = 0; k < 15; k++) tick();
        chk("to_last", {4'h0, check_spaces[0]}, 8'h07);
        tick();
        chk("to_cleared", {4'h0, space_item[0]}, 8'h00);

        // take on the final presented cycle wins over timeout
        do_req(1'b0, 1'b0, 4'h7, 1'b1, 1'b0, 4'h0);
        for (int k = 0; k < 4; k++) tick();
        for (int k = 0; k < 15; k++) tick();
        chk("take_last", {4'h0, check_spaces[0]}, 8'h07);
        do_req(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'h7);
        chk("take_cleared", {4'h0, space_item[0]}, 8'h00);

        for (int k = 0; k < 3; k++) tick();
        chk("rq_drained", 8'(rq.size()), 8'h00);
        chk("pq_drained", 8'(pq.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
